// File: rtl/wram_pkg.sv
// Shared constants and types for the WRAM BSRAM responder.
package wram_pkg;

    localparam logic [21:0] CPU_BASE_DEF = 22'h006000;
    localparam logic [21:0] RV_BASE_DEF  = 22'h066000;
    localparam int          AW_DEF       = 13;
    localparam int          MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_RV  = 2'd2
    } gnt_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/wram_spram16.sv
// Single-port 16-bit BSRAM with byte enables and one-cycle registered read.
module wram_spram16 #(
    parameter int WAW = 12
) (
    input  logic           clk,
    input  logic           en_i,
    input  logic           we_i,
    input  logic [1:0]     be_i,
    input  logic [WAW-1:0] addr_i,
    input  logic [15:0]    din_i,
    output logic [15:0]    q_o
);

    logic [15:0] mem_q [0:(1<<WAW)-1];

    // One access per cycle: byte-lane write, or read into the output register.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                if (be_i[0]) mem_q[addr_i][7:0]  <= din_i[7:0];
                if (be_i[1]) mem_q[addr_i][15:8] <= din_i[15:8];
            end else begin
                q_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/wram_bsram_responder.sv
// NES WRAM window served from BSRAM, shared by the CPU strobe port and the
// RISC-V toggle-handshake port.
//
// state   | meaning
// IDLE    | no access this cycle
// GNT_CPU | BSRAM owned by the captured CPU request this cycle
// GNT_RV  | BSRAM owned by the live RV request this cycle
module wram_bsram_responder
    import wram_pkg::*;
#(
    parameter logic [21:0] CPU_BASE = CPU_BASE_DEF,
    parameter logic [21:0] RV_BASE  = RV_BASE_DEF,
    parameter int          AW       = AW_DEF,
    parameter int          MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_oe,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic [21:0] rv_addr,
    input  logic [15:0] rv_din,
    input  logic [1:0]  rv_ds,
    input  logic        rv_we,
    input  logic        rv_req,
    output logic        rv_req_ack,
    output logic [15:0] rv_dout,
    input  logic        i_wram_load_ongoing,
    output logic        busy
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    logic [21:0]   cpu_off, rv_off;
    logic          cpu_hit, rv_hit, cpu_strobe, rv_pend, rv_rd_inflight;
    logic          unused_rv_lsb;
    gnt_e          state_q, state_d;
    logic          resync_q;
    logic          cpu_pend_q, cpu_pend_d;
    logic [AW-1:0] cpu_addr_q;
    logic          cpu_we_q;
    logic [7:0]    cpu_din_q;
    logic [WW-1:0] cpu_wait_q, cpu_wait_d, rv_wait_q, rv_wait_d;
    logic          acc_we_q, acc_lane_q;
    logic          cpu_ack_q, rv_req_ack_q;
    logic [7:0]    cpu_dout_q;
    logic [15:0]   rv_dout_q;
    logic          ram_en, ram_we;
    logic [1:0]    ram_be;
    logic [AW-2:0] ram_addr;
    logic [15:0]   ram_din, ram_q;

    // An address below the base wraps to a huge offset, so one upper-bits test covers both ends.
    assign cpu_off       = cpu_addr - CPU_BASE;
    assign rv_off        = rv_addr - RV_BASE;
    assign cpu_hit       = (cpu_off[21:AW] == '0);
    assign rv_hit        = (rv_off[21:AW] == '0);
    assign unused_rv_lsb = rv_off[0];
    assign cpu_strobe    = (cpu_we | cpu_oe) & cpu_hit;

    // A granted RV read stays unacked for one more cycle and must not be granted twice.
    assign rv_rd_inflight = (state_q == GNT_RV) && !acc_we_q;
    assign rv_pend        = (rv_req != rv_req_ack_q) && rv_hit && !rv_rd_inflight && !resync_q;

    assign busy       = resync_q | cpu_pend_q | rv_pend | (state_q != IDLE);
    assign cpu_ack    = cpu_ack_q;
    assign cpu_dout   = cpu_dout_q;
    assign rv_req_ack = rv_req_ack_q;
    assign rv_dout    = rv_dout_q;

    // Grant arbitration, wait counters, CPU pending flag and BSRAM port drive.
    always_comb begin
        state_d  = IDLE;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = BE_NONE;
        ram_addr = '0;
        ram_din  = '0;

        if (!resync_q) begin
            if (cpu_pend_q && rv_pend) begin
                if (cpu_wait_q >= WAIT_LIM)     state_d = GNT_CPU;
                else if (rv_wait_q >= WAIT_LIM) state_d = GNT_RV;
                else if (i_wram_load_ongoing)   state_d = GNT_RV;
                else                            state_d = GNT_CPU;
            end else if (cpu_pend_q) begin
                state_d = GNT_CPU;
            end else if (rv_pend) begin
                state_d = GNT_RV;
            end
        end

        cpu_wait_d = '0;
        if (cpu_pend_q && state_d != GNT_CPU)
            cpu_wait_d = (cpu_wait_q >= WAIT_LIM) ? WAIT_LIM : cpu_wait_q + 1'b1;
        rv_wait_d = '0;
        if (rv_pend && state_d != GNT_RV)
            rv_wait_d = (rv_wait_q >= WAIT_LIM) ? WAIT_LIM : rv_wait_q + 1'b1;

        cpu_pend_d = cpu_pend_q && (state_d != GNT_CPU);
        if (cpu_strobe) cpu_pend_d = 1'b1;

        case (state_d)
            GNT_CPU: begin
                ram_en   = 1'b1;
                ram_we   = cpu_we_q;
                ram_be   = cpu_addr_q[0] ? BE_HI : BE_LO;
                ram_addr = cpu_addr_q[AW-1:1];
                ram_din  = {cpu_din_q, cpu_din_q};
            end
            GNT_RV: begin
                ram_en   = 1'b1;
                ram_we   = rv_we;
                ram_be   = rv_ds;
                ram_addr = rv_off[AW-1:1];
                ram_din  = rv_din;
            end
            default: ;
        endcase
    end

    // Registered state, handshake outputs and read-return path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            resync_q     <= 1'b1;
            cpu_pend_q   <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_we_q     <= 1'b0;
            cpu_din_q    <= '0;
            cpu_wait_q   <= '0;
            rv_wait_q    <= '0;
            acc_we_q     <= 1'b0;
            acc_lane_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            rv_req_ack_q <= 1'b0;
            rv_dout_q    <= '0;
        end else begin
            resync_q   <= 1'b0;
            state_q    <= state_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_wait_q <= cpu_wait_d;
            rv_wait_q  <= rv_wait_d;
            cpu_ack_q  <= 1'b0;

            if (cpu_strobe) begin
                cpu_addr_q <= cpu_off[AW-1:0];
                cpu_we_q   <= cpu_we;
                cpu_din_q  <= cpu_din;
            end

            // Whatever toggle was outstanding across reset is abandoned.
            if (resync_q) rv_req_ack_q <= rv_req;

            if (state_d == GNT_CPU) begin
                acc_we_q   <= cpu_we_q;
                acc_lane_q <= cpu_addr_q[0];
                if (cpu_we_q) cpu_ack_q <= 1'b1;
            end
            if (state_d == GNT_RV) begin
                acc_we_q <= rv_we;
                if (rv_we) rv_req_ack_q <= ~rv_req_ack_q;
            end

            if (state_q == GNT_CPU && !acc_we_q) begin
                cpu_dout_q <= acc_lane_q ? ram_q[15:8] : ram_q[7:0];
                cpu_ack_q  <= 1'b1;
            end
            if (state_q == GNT_RV && !acc_we_q) begin
                rv_dout_q    <= ram_q;
                rv_req_ack_q <= ~rv_req_ack_q;
            end
        end
    end

    wram_spram16 #(.WAW(AW - 1)) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .addr_i (ram_addr),
        .din_i  (ram_din),
        .q_o    (ram_q)
    );

endmodule

// File: tb/tb_wram_bsram_responder.sv
// Directed bench for the WRAM BSRAM responder.
module tb_wram_bsram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] cpu_addr;
    logic        cpu_we, cpu_oe;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic [21:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we, rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;
    logic        load;
    logic        busy;
    logic        cpu_out = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        is_rv;
        logic        we;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  ds;
        int          lat;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    wram_bsram_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_addr            (cpu_addr),
        .cpu_we              (cpu_we),
        .cpu_oe              (cpu_oe),
        .cpu_din             (cpu_din),
        .cpu_dout            (cpu_dout),
        .cpu_ack             (cpu_ack),
        .rv_addr             (rv_addr),
        .rv_din              (rv_din),
        .rv_ds               (rv_ds),
        .rv_we               (rv_we),
        .rv_req              (rv_req),
        .rv_req_ack          (rv_req_ack),
        .rv_dout             (rv_dout),
        .i_wram_load_ongoing (load),
        .busy                (busy)
    );

    always @(posedge clk)
        if (cpu_out && (cpu_we || cpu_oe)) $error("FAIL strobe_while_pending");

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cpu_dout"}, cpu_dout, 0);
        check({tag, "_cpu_ack"}, cpu_ack, 0);
        check({tag, "_rv_dout"}, rv_dout, 0);
        check({tag, "_rv_req_ack"}, rv_req_ack, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    function automatic vec_t mk(logic is_rv, logic we, logic [21:0] addr, logic [15:0] din,
                                logic [1:0] ds, int lat, logic [15:0] dout);
        vec_t v;
        v.is_rv = is_rv; v.we = we; v.addr = addr; v.din = din;
        v.ds = ds; v.lat = lat; v.dout = dout;
        return v;
    endfunction

    // Issue one access at the current negedge; lat counts negedges until the ack (0 = never).
    task automatic run_vec(input vec_t v, input string name);
        int          lat;
        logic [15:0] d;
        lat = 0;
        d   = '0;
        if (v.is_rv) begin
            rv_addr = v.addr; rv_din = v.din; rv_ds = v.ds; rv_we = v.we;
            rv_req  = ~rv_req;
        end else begin
            cpu_addr = v.addr; cpu_din = v.din[7:0];
            cpu_we = v.we; cpu_oe = !v.we;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_we = 1'b0; cpu_oe = 1'b0;
                if (v.lat != 0) begin
                    check({name, "_busy_active"}, busy, 1);
                    if (!v.is_rv) cpu_out = 1'b1;
                end
            end
            if (!v.is_rv && cpu_ack) begin
                lat = k; d = {8'h00, cpu_dout}; cpu_out = 1'b0; break;
            end
            if (v.is_rv && rv_req_ack == rv_req) begin
                lat = k; d = rv_dout; break;
            end
        end
        if (v.is_rv && lat == 0) rv_req = ~rv_req;
        check({name, "_lat"}, lat, v.lat);
        if (v.lat != 0 && !v.we) check({name, "_data"}, d, v.dout);
        @(negedge clk);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    // CPU and RV write the same byte with both pending in the same cycle.
    task automatic race(input logic ld, input logic [7:0] exp, input string name);
        int cpu_t, rv_t;
        cpu_t = 0; rv_t = 0;
        load = ld;
        cpu_addr = 22'h006020; cpu_din = 8'h11; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0; cpu_out = 1'b1;
        rv_addr = 22'h066020; rv_din = 16'h0022; rv_ds = 2'b01; rv_we = 1'b1;
        rv_req = ~rv_req;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (cpu_ack && cpu_t == 0) begin cpu_t = k; cpu_out = 1'b0; end
            if (rv_req_ack == rv_req && rv_t == 0) rv_t = k;
        end
        check({name, "_cpu_order"}, cpu_t, ld ? 2 : 1);
        check({name, "_rv_order"}, rv_t, ld ? 1 : 2);
        load = 1'b0;
        run_vec(mk(0, 0, 22'h006020, 16'h0, 2'b00, 3, {8'h00, exp}), {name, "_readback"});
    endtask

    initial begin
        int          t;
        logic [7:0]  d8;

        reset = 1'b1; cpu_addr = '0; cpu_we = 0; cpu_oe = 0; cpu_din = '0;
        rv_addr = '0; rv_din = '0; rv_ds = '0; rv_we = 0; rv_req = 0; load = 0;
        #1;
        check_reset("rst0");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst0_resync_ack", rv_req_ack, 0);
        check("rst0_resync_busy", busy, 0);

        vecs.push_back(mk(0, 1, 22'h006001, 16'h00A5, 2'b00, 2, 16'h0));
        vecs.push_back(mk(0, 0, 22'h006001, 16'h0000, 2'b00, 3, 16'h00A5));
        vecs.push_back(mk(1, 1, 22'h066010, 16'h1234, 2'b11, 1, 16'h0));
        vecs.push_back(mk(0, 0, 22'h006010, 16'h0000, 2'b00, 3, 16'h0034));
        vecs.push_back(mk(0, 0, 22'h006011, 16'h0000, 2'b00, 3, 16'h0012));
        vecs.push_back(mk(1, 0, 22'h066011, 16'h0000, 2'b00, 2, 16'h1234));
        vecs.push_back(mk(1, 1, 22'h066010, 16'hABCD, 2'b10, 1, 16'h0));
        vecs.push_back(mk(1, 0, 22'h066010, 16'h0000, 2'b00, 2, 16'hAB34));
        vecs.push_back(mk(1, 1, 22'h066010, 16'hFFFF, 2'b00, 1, 16'h0));
        vecs.push_back(mk(1, 0, 22'h066010, 16'h0000, 2'b00, 2, 16'hAB34));
        vecs.push_back(mk(0, 1, 22'h006000, 16'h0077, 2'b00, 2, 16'h0));
        vecs.push_back(mk(0, 1, 22'h007FFE, 16'h00C3, 2'b00, 2, 16'h0));
        vecs.push_back(mk(0, 1, 22'h007FFF, 16'h005A, 2'b00, 2, 16'h0));
        vecs.push_back(mk(1, 0, 22'h067FFE, 16'h0000, 2'b00, 2, 16'h5AC3));
        vecs.push_back(mk(0, 1, 22'h005FFF, 16'h00EE, 2'b00, 0, 16'h0));
        vecs.push_back(mk(1, 1, 22'h068000, 16'hFFFF, 2'b11, 0, 16'h0));
        vecs.push_back(mk(0, 1, 22'h008000, 16'h00EE, 2'b00, 0, 16'h0));
        vecs.push_back(mk(1, 1, 22'h065FFE, 16'hFFFF, 2'b11, 0, 16'h0));
        vecs.push_back(mk(1, 0, 22'h066000, 16'h0000, 2'b00, 2, 16'hA577));
        vecs.push_back(mk(1, 0, 22'h067FFE, 16'h0000, 2'b00, 2, 16'h5AC3));
        vecs.push_back(mk(0, 0, 22'h007FFF, 16'h0000, 2'b00, 3, 16'h005A));
        vecs.push_back(mk(1, 0, 22'h066010, 16'h0000, 2'b00, 2, 16'hAB34));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        race(1'b0, 8'h22, "race_load0");
        race(1'b1, 8'h11, "race_load1");

        // RV keeps re-requesting every cycle under load priority; CPU read must still get through.
        load = 1'b1;
        rv_addr = 22'h066040; rv_din = 16'h0000; rv_ds = 2'b11; rv_we = 1'b1;
        t = 0; d8 = '0;
        for (int k = 0; k <= 30; k++) begin
            if (k > 2 && cpu_ack) begin t = k - 2; d8 = cpu_dout; cpu_out = 1'b0; break; end
            if (rv_req_ack == rv_req) rv_req = ~rv_req;
            if (k == 2) begin cpu_addr = 22'h006001; cpu_oe = 1'b1; end
            if (k == 3) begin cpu_oe = 1'b0; cpu_out = 1'b1; end
            @(negedge clk);
        end
        check("starve_lat_within", (t >= 1 && t <= 7), 1);
        check("starve_data", d8, 8'hA5);
        load = 1'b0;
        for (int k = 0; k < 6 && rv_req_ack != rv_req; k++) @(negedge clk);
        check("starve_rv_drained", rv_req_ack, rv_req);
        @(negedge clk);

        // Reset lands while an RV read is in flight: nothing may be acked.
        rv_we = 1'b0; rv_addr = 22'h066010; rv_req = ~rv_req;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ack_resync", rv_req_ack, rv_req);
        check("rst_mid_no_data", rv_dout, 0);
        check("rst_mid_busy", busy, 0);

        // Reset with an in-window RV write toggle held: it must be dropped.
        @(negedge clk);
        reset = 1'b1;
        rv_req = 1'b1; rv_addr = 22'h066000; rv_we = 1'b1; rv_din = 16'hFFFF; rv_ds = 2'b11;
        #1;
        check_reset("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hold_ack", rv_req_ack, 1);
        check("rst_hold_busy", busy, 0);
        run_vec(mk(0, 0, 22'h006000, 16'h0, 2'b00, 3, 16'h0077), "rst_hold_w0_lo");
        run_vec(mk(0, 0, 22'h006001, 16'h0, 2'b00, 3, 16'h00A5), "rst_hold_w0_hi");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
